// File: rtl/fifo_bist_checker.sv
// fifo_bist_checker: traffic generator and in-order scoreboard for a single-clock FIFO.
// Define FIFO_BIST_TIMEOUT_EN to add a 65536-cycle stall watchdog and a timeout output.
module fifo_bist_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_WIDTH = 11,
  parameter int RD_LATENCY = 1,
  parameter int ERR_CNT_WIDTH = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic tb_rst,
  input  logic start,
  input  logic [1:0] mode,
  output logic wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic wr_full,
  output logic rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic rd_empty,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [DEPTH_WIDTH:0] first_err_idx
`ifdef FIFO_BIST_TIMEOUT_EN
  ,
  output logic timeout
`endif
);
  localparam int CW = DEPTH_WIDTH + 1;
  localparam int FW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] N = {1'b1, {DEPTH_WIDTH{1'b0}}};
  typedef enum logic [2:0] {IDLE, FILL, DRAIN, STREAM, FLUSH, DONE} state_t;
  state_t state;
  logic [CW-1:0] wr_cnt, rd_cnt, target;
  logic [15:0] lfsr;
  logic thr, data_seen;
  logic [FW-1:0] flush_cnt;
  logic pipe_v [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_exp [RD_LATENCY];
  logic [CW-1:0] pipe_idx [RD_LATENCY];
  logic data_err, fill_err, flush_err, last_flush;
  logic [ERR_CNT_WIDTH-1:0] err_nxt;
  always_comb begin
    wr_en = (state == FILL || state == STREAM) && !wr_full && wr_cnt < N && (!thr || state == FILL || lfsr[0]);
    rd_en = !rd_empty && ((state == DRAIN && rd_cnt < target) || (state == STREAM && rd_cnt < N && (!thr || lfsr[5])));
    wr_data = ~DATA_WIDTH'(wr_cnt);
    data_err = pipe_v[RD_LATENCY-1] && rd_data != pipe_exp[RD_LATENCY-1];
    fill_err = state == FILL && (wr_cnt == N ? !wr_full : wr_full);
    last_flush = state == FLUSH && flush_cnt == FW'(RD_LATENCY - 1);
    flush_err = last_flush && !rd_empty;
    // a data and a flag error in the same cycle count once
    err_nxt = ((data_err || fill_err || flush_err) && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  end
`ifdef FIFO_BIST_TIMEOUT_EN
  logic [15:0] wdog;
  logic running, stall;
  always_comb begin
    running = state == FILL || state == DRAIN || state == STREAM;
    stall = running && !wr_en && !rd_en && wdog == 16'hFFFF;
  end
`endif
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state <= IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      target <= '0;
      lfsr <= LFSR_SEED;
      thr <= 1'b0;
      data_seen <= 1'b0;
      flush_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      first_err_idx <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_exp[i] <= '0;
        pipe_idx[i] <= '0;
      end
`ifdef FIFO_BIST_TIMEOUT_EN
      wdog <= '0;
      timeout <= 1'b0;
`endif
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pipe_v[0] <= rd_en;
      pipe_exp[0] <= ~DATA_WIDTH'(rd_cnt);
      pipe_idx[0] <= rd_cnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      err_cnt <= err_nxt;
      if (data_err && !data_seen) begin
        data_seen <= 1'b1;
        first_err_idx <= pipe_idx[RD_LATENCY-1];
      end
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      case (state)
        IDLE, DONE: if (start) begin
          state <= (mode == 2'b01 || mode == 2'b10) ? STREAM : FILL;
          thr <= mode == 2'b10;
          busy <= 1'b1;
          done <= 1'b0;
          pass <= 1'b0;
          err_cnt <= '0;
          first_err_idx <= '0;
          data_seen <= 1'b0;
          wr_cnt <= '0;
          rd_cnt <= '0;
          flush_cnt <= '0;
        end
        // an early full flag truncates the pass to what was actually written
        FILL: if (wr_cnt == N || wr_full) begin
          target <= wr_cnt;
          state <= DRAIN;
        end
        DRAIN: if (rd_cnt == target) state <= FLUSH;
        STREAM: if (wr_cnt == N && rd_cnt == N) state <= FLUSH;
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (last_flush) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_nxt == '0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef FIFO_BIST_TIMEOUT_EN
      wdog <= (!running || wr_en || rd_en) ? '0 : wdog + 1'b1;
      if (stall) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        pass <= 1'b0;
        timeout <= 1'b1;
      end
      if ((state == IDLE || state == DONE) && start) timeout <= 1'b0;
`endif
    end
  end
endmodule
